// File: rtl/iq_issue_sel.sv
// iq_issue_sel: picks hazard-free IQ head slots, drives extraction back to the IQ, registers compacted issue lanes and owns the register-busy scoreboard.
module iq_issue_sel #(
  parameter int EXT_COUNT = 4,
  parameter int NREGS     = 32,
  parameter int REGLOG2   = 5,
  parameter int ROBLOG2   = 5,
  parameter int ALU_PORTS = 2,
  parameter int WB_COUNT  = 4,
  localparam int LW = (EXT_COUNT > 1) ? $clog2(EXT_COUNT) : 1,
  localparam int CW = $clog2(EXT_COUNT + 1)
) (
  input  logic                                  clock_i,
  input  logic                                  reset_n_i,
  input  logic [EXT_COUNT-1:0]                  slot_valid_i,
  input  logic [EXT_COUNT-1:0][REGLOG2-1:0]     slot_srca_i,
  input  logic [EXT_COUNT-1:0][REGLOG2-1:0]     slot_srcb_i,
  input  logic [EXT_COUNT-1:0][REGLOG2-1:0]     slot_dst_i,
  input  logic [EXT_COUNT-1:0]                  slot_srca_en_i,
  input  logic [EXT_COUNT-1:0]                  slot_srcb_en_i,
  input  logic [EXT_COUNT-1:0]                  slot_dst_en_i,
  input  logic [EXT_COUNT-1:0][1:0]             slot_unit_i,
  input  logic [EXT_COUNT-1:0][ROBLOG2-1:0]     slot_rob_i,
  input  logic [EXT_COUNT-1:0]                  slot_stream_i,
  input  logic [3:0]                            unit_ready_i,
  input  logic [WB_COUNT-1:0]                   wb_valid_i,
  input  logic [WB_COUNT-1:0][REGLOG2-1:0]      wb_dst_i,
  input  logic                                  flush_i,
  input  logic                                  flush_stream_i,
  output logic                                  ext_enable_o,
  output logic [EXT_COUNT-1:0]                  ext_consumed_o,
  output logic [EXT_COUNT-1:0]                  iss_valid_o,
  output logic [EXT_COUNT-1:0][LW-1:0]          iss_slot_o,
  output logic [EXT_COUNT-1:0][ROBLOG2-1:0]     iss_rob_o,
  output logic [EXT_COUNT-1:0][1:0]             iss_unit_o,
  output logic [EXT_COUNT-1:0]                  iss_stream_o
);
  logic [NREGS-1:0]                  busy_q, busy_d, tag_q, tag_d;
  logic [EXT_COUNT-1:0]              iss_valid_q, iss_valid_d, iss_stream_q, iss_stream_d;
  logic [EXT_COUNT-1:0][LW-1:0]      iss_slot_q, iss_slot_d;
  logic [EXT_COUNT-1:0][ROBLOG2-1:0] iss_rob_q, iss_rob_d;
  logic [EXT_COUNT-1:0][1:0]         iss_unit_q, iss_unit_d;
  logic [EXT_COUNT-1:0]              issue;
  logic                              ok;
  logic [CW-1:0]                     cnt;
  logic [LW-1:0]                     n;

  // Oldest-first selection: each slot checks the scoreboard, hazards against older slots, and per-class port budget.
  always_comb begin
    issue = '0;
    ok    = 1'b0;
    cnt   = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      ok  = slot_valid_i[i] && unit_ready_i[slot_unit_i[i]] && !flush_i;
      cnt = '0;
      if (slot_srca_en_i[i] && slot_srca_i[i] != '0 && busy_q[slot_srca_i[i]]) ok = 1'b0;
      if (slot_srcb_en_i[i] && slot_srcb_i[i] != '0 && busy_q[slot_srcb_i[i]]) ok = 1'b0;
      if (slot_dst_en_i[i] && slot_dst_i[i] != '0 && busy_q[slot_dst_i[i]]) ok = 1'b0;
      for (int j = 0; j < i; j++) begin
        if (slot_valid_i[j]) begin
          if (slot_dst_en_i[j] && ((slot_srca_en_i[i] && slot_dst_i[j] == slot_srca_i[i]) ||
                                   (slot_srcb_en_i[i] && slot_dst_i[j] == slot_srcb_i[i]))) ok = 1'b0;
          if (slot_dst_en_i[j] && slot_dst_en_i[i] && slot_dst_i[j] == slot_dst_i[i]) ok = 1'b0;
          if (!issue[j] && slot_dst_en_i[i] && ((slot_srca_en_i[j] && slot_srca_i[j] == slot_dst_i[i]) ||
                                                (slot_srcb_en_i[j] && slot_srcb_i[j] == slot_dst_i[i]))) ok = 1'b0;
          if (!issue[j] && slot_unit_i[i] != 2'd0 && slot_unit_i[j] == slot_unit_i[i]) ok = 1'b0;
          if (issue[j] && slot_unit_i[j] == slot_unit_i[i]) cnt = cnt + CW'(1);
        end
      end
      issue[i] = ok && (cnt < ((slot_unit_i[i] == 2'd0) ? CW'(ALU_PORTS) : CW'(1)));
    end
  end

  // Pack issuing slots into lanes from lane 0 upward, keeping slot order.
  always_comb begin
    iss_valid_d  = '0;
    iss_slot_d   = '0;
    iss_rob_d    = '0;
    iss_unit_d   = '0;
    iss_stream_d = '0;
    n            = '0;
    for (int i = 0; i < EXT_COUNT; i++) begin
      if (issue[i]) begin
        iss_valid_d[n]  = 1'b1;
        iss_slot_d[n]   = LW'(i);
        iss_rob_d[n]    = slot_rob_i[i];
        iss_unit_d[n]   = slot_unit_i[i];
        iss_stream_d[n] = slot_stream_i[i];
        n               = n + LW'(1);
      end
    end
  end

  // Scoreboard update, applied lowest priority first: writeback clear, issue set, flush clear; reg 0 stays idle.
  always_comb begin
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int w = 0; w < WB_COUNT; w++)
      if (wb_valid_i[w]) busy_d[wb_dst_i[w]] = 1'b0;
    for (int i = 0; i < EXT_COUNT; i++)
      if (issue[i] && slot_dst_en_i[i] && slot_dst_i[i] != '0) begin
        busy_d[slot_dst_i[i]] = 1'b1;
        tag_d[slot_dst_i[i]]  = slot_stream_i[i];
      end
    if (flush_i)
      for (int r = 0; r < NREGS; r++)
        if (tag_q[r] == flush_stream_i) busy_d[r] = 1'b0;
    busy_d[0] = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy_q       <= '0;
      tag_q        <= '0;
      iss_valid_q  <= '0;
      iss_slot_q   <= '0;
      iss_rob_q    <= '0;
      iss_unit_q   <= '0;
      iss_stream_q <= '0;
    end else begin
      busy_q       <= busy_d;
      tag_q        <= tag_d;
      iss_valid_q  <= iss_valid_d;
      iss_slot_q   <= iss_slot_d;
      iss_rob_q    <= iss_rob_d;
      iss_unit_q   <= iss_unit_d;
      iss_stream_q <= iss_stream_d;
    end
  end

  assign ext_consumed_o = issue;
  assign ext_enable_o   = |issue;
  assign iss_valid_o    = iss_valid_q;
  assign iss_slot_o     = iss_slot_q;
  assign iss_rob_o      = iss_rob_q;
  assign iss_unit_o     = iss_unit_q;
  assign iss_stream_o   = iss_stream_q;
endmodule

// File: tb/tb_iq_issue_sel.sv
// tb_iq_issue_sel: directed checks of selection, lane packing, scoreboard, flush and reset.
module tb_iq_issue_sel;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0]      slot_valid, srca_en, srcb_en, dst_en, stream, unit_ready, wb_valid;
  logic [3:0][4:0] srca, srcb, dst, rob, wb_dst;
  logic [3:0][1:0] unit;
  logic            flush, flush_stream;
  logic            ext_enable;
  logic [3:0]      ext_consumed, iss_valid, iss_stream;
  logic [3:0][1:0] iss_slot, iss_unit;
  logic [3:0][4:0] iss_rob;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iq_issue_sel dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .slot_valid_i(slot_valid), .slot_srca_i(srca), .slot_srcb_i(srcb), .slot_dst_i(dst),
    .slot_srca_en_i(srca_en), .slot_srcb_en_i(srcb_en), .slot_dst_en_i(dst_en),
    .slot_unit_i(unit), .slot_rob_i(rob), .slot_stream_i(stream),
    .unit_ready_i(unit_ready), .wb_valid_i(wb_valid), .wb_dst_i(wb_dst),
    .flush_i(flush), .flush_stream_i(flush_stream),
    .ext_enable_o(ext_enable), .ext_consumed_o(ext_consumed), .iss_valid_o(iss_valid),
    .iss_slot_o(iss_slot), .iss_rob_o(iss_rob), .iss_unit_o(iss_unit), .iss_stream_o(iss_stream)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    slot_valid = '0; srca = '0; srcb = '0; dst = '0;
    srca_en = '0; srcb_en = '0; dst_en = '0; unit = '0; rob = '0; stream = '0;
    unit_ready = 4'hF; wb_valid = '0; wb_dst = '0; flush = 1'b0; flush_stream = 1'b0;
  endtask

  task automatic put(input int i, input logic [1:0] u, input logic [4:0] a, input logic ae,
                     input logic [4:0] b, input logic be, input logic [4:0] d, input logic de,
                     input logic [4:0] r, input logic st);
    slot_valid[i] = 1'b1; unit[i] = u; srca[i] = a; srca_en[i] = ae; srcb[i] = b; srcb_en[i] = be;
    dst[i] = d; dst_en[i] = de; rob[i] = r; stream[i] = st;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    #3;
    chk("rst_iss_valid", iss_valid, 4'b0000);
    chk("rst_consumed", ext_consumed, 4'b0000);
    chk("rst_enable", ext_enable, 1'b0);
    chk("rst_busy", dut.busy_q, 32'h0);
    #9 rst_n = 1'b1;
    tick();
    // four independent ALU slots, two ALU ports
    put(0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h0A, 1'b0);
    put(1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h0B, 1'b0);
    put(2, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h0C, 1'b0);
    put(3, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h0D, 1'b0);
    #1;
    chk("t1_consumed", ext_consumed, 4'b0011);
    chk("t1_enable", ext_enable, 1'b1);
    chk("t1_pre_iss_valid", iss_valid, 4'b0000);
    tick();
    chk("t1_iss_valid", iss_valid, 4'b0011);
    chk("t1_rob0", iss_rob[0], 5'h0A);
    chk("t1_rob1", iss_rob[1], 5'h0B);
    chk("t1_slot1", iss_slot[1], 2'd1);
    // RAW on r5, then writeback frees it
    idle();
    put(0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 5'h01, 1'b0);
    put(1, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'h02, 1'b0);
    #1;
    chk("t2_consumed", ext_consumed, 4'b0001);
    tick();
    chk("t2_busy_r5", dut.busy_q[5], 1'b1);
    chk("t2_iss_valid", iss_valid, 4'b0001);
    chk("t2_rob0", iss_rob[0], 5'h01);
    idle();
    put(0, 2'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'h02, 1'b0);
    wb_valid = 4'b0001; wb_dst[0] = 5'd5;
    #1;
    chk("t2_blocked", ext_consumed, 4'b0000);
    tick();
    chk("t2_iss_none", iss_valid, 4'b0000);
    chk("t2_busy_r5_clr", dut.busy_q[5], 1'b0);
    wb_valid = '0;
    #1;
    chk("t2_released", ext_consumed, 4'b0001);
    tick();
    chk("t2_iss_late", iss_valid, 4'b0001);
    chk("t2_rob_late", iss_rob[0], 5'h02);
    // MEM class not ready blocks both MEM slots in order; ALU passes
    idle();
    unit_ready = 4'b1101;
    put(0, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h03, 1'b0);
    put(1, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h04, 1'b0);
    put(2, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h05, 1'b0);
    #1;
    chk("t3_consumed", ext_consumed, 4'b0100);
    tick();
    chk("t3_iss_valid", iss_valid, 4'b0001);
    chk("t3_slot0", iss_slot[0], 2'd2);
    chk("t3_rob0", iss_rob[0], 5'h05);
    // one BR and one MULDIV per cycle
    idle();
    put(0, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h06, 1'b0);
    put(1, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h07, 1'b0);
    put(2, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h08, 1'b0);
    put(3, 2'd3, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h09, 1'b0);
    #1;
    chk("lim_consumed", ext_consumed, 4'b0101);
    tick();
    chk("lim_iss_valid", iss_valid, 4'b0011);
    chk("lim_slot1", iss_slot[1], 2'd2);
    chk("lim_unit1", iss_unit[1], 2'd3);
    // WAR on r12 behind a stalled reader, RAW on r13 behind an issuing writer
    idle();
    unit_ready = 4'b1101;
    put(0, 2'd1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'h0E, 1'b0);
    put(1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 5'h0F, 1'b0);
    put(2, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 5'h10, 1'b0);
    put(3, 2'd0, 5'd0, 1'b0, 5'd13, 1'b1, 5'd0, 1'b0, 5'h11, 1'b0);
    #1;
    chk("haz_consumed", ext_consumed, 4'b0100);
    tick();
    chk("haz_busy_r13", dut.busy_q[13], 1'b1);
    chk("haz_busy_r12", dut.busy_q[12], 1'b0);
    chk("haz_slot0", iss_slot[0], 2'd2);
    // flush of stream 1 clears r7 but not r9 (stream 0)
    idle();
    put(0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 5'h12, 1'b1);
    put(1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 5'h13, 1'b0);
    #1;
    chk("t4_consumed", ext_consumed, 4'b0011);
    tick();
    chk("t4_busy_r7", dut.busy_q[7], 1'b1);
    chk("t4_busy_r9", dut.busy_q[9], 1'b1);
    chk("t4_stream0", iss_stream[0], 1'b1);
    idle();
    put(0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h14, 1'b0);
    flush = 1'b1; flush_stream = 1'b1;
    #1;
    chk("t4_flush_consumed", ext_consumed, 4'b0000);
    chk("t4_flush_enable", ext_enable, 1'b0);
    chk("t4_flush_keep_lanes", iss_valid, 4'b0011);
    tick();
    chk("t4_busy_r7_clr", dut.busy_q[7], 1'b0);
    chk("t4_busy_r9_keep", dut.busy_q[9], 1'b1);
    chk("t4_iss_after", iss_valid, 4'b0000);
    // issue set beats same-cycle writeback; r0 never busy
    idle();
    put(0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 5'h15, 1'b0);
    put(1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'h16, 1'b0);
    wb_valid = 4'b0010; wb_dst[1] = 5'd3;
    #1;
    chk("t5_consumed", ext_consumed, 4'b0011);
    tick();
    chk("t5_busy_r3", dut.busy_q[3], 1'b1);
    chk("t5_busy_r0", dut.busy_q[0], 1'b0);
    // full issue, then asynchronous reset mid-cycle
    idle();
    put(0, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h17, 1'b0);
    put(1, 2'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h18, 1'b0);
    put(2, 2'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h19, 1'b0);
    put(3, 2'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'h1A, 1'b1);
    #1;
    chk("t6_consumed", ext_consumed, 4'b1111);
    tick();
    chk("t6_iss_valid", iss_valid, 4'b1111);
    chk("t6_rob3", iss_rob[3], 5'h1A);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_iss_valid", iss_valid, 4'b0000);
    chk("t6_rst_rob3", iss_rob[3], 5'h00);
    chk("t6_rst_busy", dut.busy_q, 32'h0);
    idle();
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
